// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the banked data-RAM arbiter.
//   arb_state_t  BOOT (loader owns the RAM) / RUN (core priority)
//   owner_t      which requester a RAM slot belongs to
//   mem_tag_t    per-slot bookkeeping carried alongside the RAM latency
package dmem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    logic   is_read;
    owner_t owner;
    logic   zero;     // out-of-range slot: return zeros instead of RAM data
  } mem_tag_t;

  // addr[17:15] selects the bank, so bit 17 is the top legal address bit
  localparam int DMEM_BANK_LSB = 15;
  localparam int DMEM_BANK_W   = 3;

  function automatic logic addr_out_of_range(input logic [31:0] addr, input int hi_bit);
    return (addr >> (hi_bit + 1)) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_tag_pipe.sv
// dmem_tag_pipe: fixed-depth shift register of mem_tag_t that tracks each
// issued slot until its RAM read data is due. Synchronous clear drops every
// in-flight tag, so reads pending at reset never produce a response.
//   clk, rstn  clock / synchronous active-low clear
//   tag_in     tag of the slot accepted this cycle (valid=0 for idle)
//   tag_out    tag whose RAM data is on mem_rdata this cycle
module dmem_tag_pipe
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);

  mem_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the banked 64-bit data-RAM port between the core
// memory stage and the loader/IO DMA engine.
//
//   state | meaning
//   BOOT  | loader phase: DMA always ready, core stalled, core never issued
//   RUN   | core has priority; a DMA request losing STARVE_LIMIT cycles in a
//         | row is forced through on the next cycle
//
// Ports
//   clk, rstn                              clock, synchronous active-low reset
//   boot_done                              pulse: leave BOOT (ignored in RUN)
//   core_req/addr/wdata/wea, core_stall    core request (wea=0 read), hold on stall
//   core_rvalid/rdata                      core read response
//   dma_valid/addr/wdata/wea, dma_ready    DMA request, valid/ready handshake
//   dma_rvalid/rdata                       DMA read response
//   mem_en/addr/wdata/wea, mem_rdata       registered RAM port, fixed read latency
//   err_oob                                sticky out-of-range flag
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int READ_LATENCY = 3,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_HI_BIT  = DMEM_BANK_LSB + DMEM_BANK_W - 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        boot_done,
  input  logic        core_req,
  input  logic [31:0] core_addr,
  input  logic [63:0] core_wdata,
  input  logic [7:0]  core_wea,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,
  input  logic        dma_valid,
  input  logic [31:0] dma_addr,
  input  logic [63:0] dma_wdata,
  input  logic [7:0]  dma_wea,
  output logic        dma_ready,
  output logic        dma_rvalid,
  output logic [63:0] dma_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wea,
  input  logic [63:0] mem_rdata,
  output logic        err_oob
);

  localparam int               CNT_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_LOAD = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_left;   // lost cycles remaining before DMA is forced
  logic             core_grant, dma_grant, dma_force;
  logic             sel_valid, sel_oob, issue_go;
  owner_t           sel_owner;
  logic [31:0]      sel_addr;
  logic [63:0]      sel_wdata;
  logic [7:0]       sel_wea;
  mem_tag_t         issue_tag, resp_tag;
  logic             resp_read;
  logic [63:0]      resp_data;

  always_ff @(posedge clk) begin
    if (!rstn) state <= BOOT;
    else       state <= state_nxt;
  end

  // Handshakes are held quiet while in reset so nothing is accepted.
  always_comb begin
    state_nxt  = state;
    core_grant = 1'b0;
    dma_grant  = 1'b0;
    dma_force  = 1'b0;
    core_stall = 1'b1;
    dma_ready  = 1'b0;
    if (rstn) begin
      case (state)
        BOOT: begin
          dma_ready = 1'b1;
          dma_grant = dma_valid;
          if (boot_done) state_nxt = RUN;
        end
        RUN: begin
          dma_force  = dma_valid && (starve_left == '0);
          core_grant = core_req && !dma_force;
          core_stall = core_req && !core_grant;
          dma_ready  = !core_req || dma_force;
          dma_grant  = dma_valid && dma_ready;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // Down-counter: reloads whenever the DMA is not left waiting behind the core.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_left <= STARVE_LOAD;
    end else if (state == RUN && dma_valid && core_grant) begin
      if (starve_left != '0) starve_left <= starve_left - CNT_W'(1);
    end else begin
      starve_left <= STARVE_LOAD;
    end
  end

  always_comb begin
    sel_owner = OWN_CORE;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    sel_wea   = core_wea;
    if (!core_grant) begin
      sel_owner = OWN_DMA;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
      sel_wea   = dma_wea;
    end
  end

  assign sel_valid = core_grant || dma_grant;
  assign sel_oob   = addr_out_of_range(sel_addr, ADDR_HI_BIT);
  assign issue_go  = sel_valid && !sel_oob;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wea   <= '0;
      err_oob   <= 1'b0;
    end else begin
      mem_en    <= issue_go;
      mem_addr  <= issue_go ? sel_addr  : '0;
      mem_wdata <= issue_go ? sel_wdata : '0;
      mem_wea   <= issue_go ? sel_wea   : '0;
      if (sel_valid && sel_oob) err_oob <= 1'b1;
    end
  end

  // Out-of-range requests still occupy a slot so their (zero) read data
  // returns with normal latency and in issue order.
  always_comb begin
    issue_tag         = '0;
    issue_tag.valid   = sel_valid;
    issue_tag.is_read = (sel_wea == 8'h00);
    issue_tag.owner   = sel_owner;
    issue_tag.zero    = sel_oob;
  end

  dmem_tag_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rstn    (rstn),
    .tag_in  (issue_tag),
    .tag_out (resp_tag)
  );

  assign resp_read   = resp_tag.valid && resp_tag.is_read;
  assign resp_data   = resp_tag.zero ? 64'h0 : mem_rdata;
  assign core_rvalid = resp_read && (resp_tag.owner == OWN_CORE);
  assign dma_rvalid  = resp_read && (resp_tag.owner == OWN_DMA);
  assign core_rdata  = core_rvalid ? resp_data : 64'h0;
  assign dma_rdata   = dma_rvalid  ? resp_data : 64'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural RAM with fixed read
// latency, a transaction-level reference model checked every cycle, a
// starvation vector table, directed corner sequences and random traffic.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int RL = 3;
  localparam int SL = 8;

  logic        clk, rstn, boot_done;
  logic        core_req, core_stall, core_rvalid;
  logic [31:0] core_addr;
  logic [63:0] core_wdata, core_rdata;
  logic [7:0]  core_wea;
  logic        dma_valid, dma_ready, dma_rvalid;
  logic [31:0] dma_addr;
  logic [63:0] dma_wdata, dma_rdata;
  logic [7:0]  dma_wea;
  logic        mem_en, err_oob;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wea;

  dmem_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL), .ADDR_HI_BIT(17)) dut (
    .clk(clk), .rstn(rstn), .boot_done(boot_done),
    .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata), .core_wea(core_wea),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wea(dma_wea),
    .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wea(mem_wea),
    .mem_rdata(mem_rdata), .err_oob(err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic int ram_key(input logic [31:0] a);
    return int'({a[DMEM_BANK_LSB +: DMEM_BANK_W], a[DMEM_BANK_LSB-1:3]});
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] we);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // RAM environment: garbage on mem_rdata except where read data is due.
  logic [63:0] ram [int];
  logic [63:0] rd_d [RL];
  always @(posedge clk) begin
    logic [63:0] v;
    int k;
    v = {$urandom, $urandom};
    if (mem_en) begin
      k = ram_key(mem_addr);
      if (mem_wea == 8'h00) v = ram.exists(k) ? ram[k] : 64'h0;
      else ram[k] = merge(ram.exists(k) ? ram[k] : 64'h0, mem_wdata, mem_wea);
    end
    rd_d[0] <= v;
    for (int i = 1; i < RL; i++) rd_d[i] <= rd_d[i-1];
  end
  assign mem_rdata = rd_d[RL-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: accepted transactions, expected issue and responses.
  typedef struct { int due; bit to_dma; logic [63:0] data; } resp_t;
  resp_t       rq [$];
  logic [63:0] ref_mem [int];
  bit          m_run, m_err, x_en;
  int          m_starve;
  logic [31:0] x_addr;
  logic [63:0] x_wdata;
  logic [7:0]  x_wea;
  bit          core_acc_q, dma_acc_q;

  task automatic model_step();
    bit e_stall, e_ready, c_acc, d_acc, frc, e_cv, e_dv, oob;
    logic [63:0] e_d, wd;
    logic [31:0] a;
    logic [7:0]  we;
    resp_t r;
    c_acc = 0; d_acc = 0;
    if (!rstn) begin
      e_stall = 1; e_ready = 0;
    end else if (!m_run) begin
      e_stall = 1; e_ready = 1; d_acc = dma_valid;
    end else begin
      frc     = dma_valid && (m_starve == SL);
      c_acc   = core_req && !frc;
      e_stall = core_req && !c_acc;
      e_ready = !core_req || frc;
      d_acc   = dma_valid && e_ready;
    end
    chk("core_stall", core_stall, e_stall);
    chk("dma_ready", dma_ready, e_ready);
    chk("mem_en", mem_en, x_en);
    chk("mem_wea", mem_wea, x_en ? x_wea : 8'h00);
    if (x_en) begin
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
    end
    chk("err_oob", err_oob, m_err);
    e_cv = 0; e_dv = 0; e_d = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_cv = !rq[0].to_dma;
      e_dv = rq[0].to_dma;
      e_d  = rq[0].data;
      void'(rq.pop_front());
    end
    chk("core_rvalid", core_rvalid, e_cv);
    chk("core_rdata", core_rdata, e_cv ? e_d : 64'h0);
    chk("dma_rvalid", dma_rvalid, e_dv);
    chk("dma_rdata", dma_rdata, e_dv ? e_d : 64'h0);

    core_acc_q = c_acc;
    dma_acc_q  = d_acc;
    if (!rstn) begin
      m_run = 0; m_starve = 0; m_err = 0; x_en = 0;
      rq.delete();
    end else begin
      a  = c_acc ? core_addr  : dma_addr;
      wd = c_acc ? core_wdata : dma_wdata;
      we = c_acc ? core_wea   : dma_wea;
      oob = (a > 32'h0003_FFFF);
      x_en = (c_acc || d_acc) && !oob;
      x_addr = a; x_wdata = wd; x_wea = we;
      if ((c_acc || d_acc) && oob) m_err = 1;
      if (c_acc || d_acc) begin
        if (we == 8'h00) begin
          r.due = cyc + 1 + RL;
          r.to_dma = d_acc;
          r.data = oob ? 64'h0 : (ref_mem.exists(ram_key(a)) ? ref_mem[ram_key(a)] : 64'h0);
          rq.push_back(r);
        end else if (!oob) begin
          ref_mem[ram_key(a)] = merge(ref_mem.exists(ram_key(a)) ? ref_mem[ram_key(a)] : 64'h0, wd, we);
        end
      end
      if (m_run) begin
        if (dma_valid && c_acc) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        else m_starve = 0;
      end
      if (boot_done) m_run = 1;
    end
    cyc++;
  endtask

  task automatic step(); @(negedge clk); model_step(); endtask
  task automatic next(); @(posedge clk); #1; endtask
  task automatic run1(); step(); next(); endtask

  task automatic idle_inputs();
    boot_done = 0;
    core_req = 0; core_addr = 0; core_wdata = 0; core_wea = 0;
    dma_valid = 0; dma_addr = 0; dma_wdata = 0; dma_wea = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 19) == 0)
      return (32'h1 << $urandom_range(18, 31)) | (32'($urandom_range(0, 7)) << 3);
    return (32'($urandom_range(0, 7)) << 15) | (32'($urandom_range(0, 7)) << 3);
  endfunction

  task automatic rand_inputs(input bit allow_boot);
    if (!(core_req && !core_acc_q)) begin
      core_req   = ($urandom_range(0, 2) != 0);
      core_addr  = rand_addr();
      core_wdata = {$urandom, $urandom};
      core_wea   = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
    end
    if (!(dma_valid && !dma_acc_q)) begin
      dma_valid = ($urandom_range(0, 1) != 0);
      dma_addr  = rand_addr();
      dma_wdata = {$urandom, $urandom};
      dma_wea   = $urandom_range(0, 1) ? 8'h00 : 8'($urandom);
    end
    boot_done = allow_boot && ($urandom_range(0, 49) == 0);
  endtask

  typedef struct { bit core_req; bit dma_valid; bit exp_stall; bit exp_ready; } tv_t;
  tv_t tbl [20];

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].core_req  = 1;
      tbl[i].dma_valid = 1;
      tbl[i].exp_stall = (i == 8 || i == 17);
      tbl[i].exp_ready = (i == 8 || i == 17);
    end
    m_run = 0; m_err = 0; x_en = 0; m_starve = 0;
    core_acc_q = 0; dma_acc_q = 0;
    idle_inputs();
    rstn = 0;
    run1();
    run1();
    rstn = 1;

    // BOOT: core read to 0x100 is never issued
    core_req = 1; core_addr = 32'h100; core_wea = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("boot_core_stall", core_stall, 1);
      chk("boot_mem_en", mem_en, 0);
      next();
    end
    idle_inputs();

    // BOOT DMA write, leave BOOT, core reads it back
    dma_valid = 1; dma_addr = 32'h8; dma_wdata = 64'hDEADBEEF_00000001; dma_wea = 8'hFF;
    step(); chk("boot_dma_ready", dma_ready, 1); next();
    idle_inputs(); boot_done = 1;
    run1();
    idle_inputs();
    core_req = 1; core_addr = 32'h8; core_wea = 0;
    step(); chk("run_core_accept", core_stall, 0); next();
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("boot_rd_rvalid", core_rvalid, k == 4);
      if (k == 4) chk("boot_rd_data", core_rdata, 64'hDEADBEEF_00000001);
      next();
    end

    // Starvation guard
    run1();
    for (int i = 0; i < 20; i++) begin
      core_req = tbl[i].core_req; core_addr = 32'h20; core_wea = 0;
      dma_valid = tbl[i].dma_valid; dma_addr = 32'h28; dma_wea = 0;
      step();
      chk("starve_core_stall", core_stall, tbl[i].exp_stall);
      chk("starve_dma_ready", dma_ready, tbl[i].exp_ready);
      next();
    end
    idle_inputs();
    for (int i = 0; i < RL + 2; i++) run1();

    // Writes, same-address write->read, interleaved core/DMA reads
    dma_valid = 1; dma_addr = 32'h18; dma_wdata = 64'h5555_6666_7777_8888; dma_wea = 8'hFF;
    run1(); idle_inputs();
    core_req = 1; core_addr = 32'h10; core_wdata = 64'h1111_2222_3333_4444; core_wea = 8'hFF;
    run1(); idle_inputs();
    core_req = 1; core_addr = 32'h10; core_wea = 0;
    run1(); idle_inputs();
    dma_valid = 1; dma_addr = 32'h18; dma_wea = 0;
    run1(); idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("il_core_rvalid", core_rvalid, k == 3);
      chk("il_dma_rvalid", dma_rvalid, k == 4);
      if (k == 3) chk("il_core_rdata", core_rdata, 64'h1111_2222_3333_4444);
      if (k == 4) chk("il_dma_rdata", dma_rdata, 64'h5555_6666_7777_8888);
      next();
    end

    // Out-of-range core read
    core_req = 1; core_addr = 32'h0004_0000; core_wea = 0;
    step(); chk("oob_accept", core_stall, 0); next();
    idle_inputs();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) begin
        chk("oob_err", err_oob, 1);
        chk("oob_mem_en", mem_en, 0);
      end
      chk("oob_rvalid", core_rvalid, k == 4);
      if (k == 4) chk("oob_rdata", core_rdata, 64'h0);
      next();
    end

    // Random RUN traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs(1);
      run1();
    end
    idle_inputs();
    for (int i = 0; i < RL + 2; i++) run1();
    step(); chk("err_sticky", err_oob, 1); next();

    // Reset two cycles after a DMA read issues
    dma_valid = 1; dma_addr = 32'h8; dma_wea = 0;
    step(); chk("rst_dma_accept", dma_ready, 1); next();
    idle_inputs();
    run1();
    run1();
    rstn = 0;
    for (int k = 3; k <= 8; k++) begin
      step();
      chk("rst_no_dma_rvalid", dma_rvalid, 0);
      if (k == 4) begin
        chk("rst_core_stall", core_stall, 1);
        chk("rst_dma_ready", dma_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_err_oob", err_oob, 0);
        chk("rst_core_rvalid", core_rvalid, 0);
      end
      next();
      if (k == 4) rstn = 1;
    end

    // Random BOOT traffic, then RUN with stray boot_done pulses
    for (int i = 0; i < 200; i++) begin
      rand_inputs(0);
      run1();
    end
    boot_done = 1;
    run1();
    boot_done = 0;
    for (int i = 0; i < 1000; i++) begin
      rand_inputs(1);
      run1();
    end
    idle_inputs();
    for (int i = 0; i < RL + 3; i++) run1();
    chk("resp_queue_drained", 64'(rq.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
